// File: rtl/directive_fifo.sv
// directive_fifo: single-clock valid/ready FIFO with show-ahead read data
// and optional saturating debug statistics (DIRECTIVE_FIFO_DBG).
module directive_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             almost_full
`ifdef DIRECTIVE_FIFO_DBG
    ,
    output logic [15:0]      drop_cnt,
    output logic [CW-1:0]    high_water
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push, pop;

    // Handshake flags decode only registered state; a full FIFO never
    // accepts a write even when the head is being popped this cycle.
    assign wr_ready    = (count != CW'(DEPTH));
    assign rd_valid    = (count != '0);
    assign almost_full = (count >= CW'(AF_THRESH));
    assign push        = wr_valid && wr_ready;
    assign pop         = rd_valid && rd_ready;
    assign rd_data     = mem[rd_ptr];

    // Next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

`ifdef DIRECTIVE_FIFO_DBG
    // Refused-write counter saturates; high-water tracks peak next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt   <= '0;
            high_water <= '0;
        end else begin
            if (wr_valid && !wr_ready && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (count_nxt > high_water)
                high_water <= count_nxt;
        end
    end
`endif

endmodule

// File: doc/directive_fifo.md
# directive_fifo

Parametrised single-clock synchronous FIFO with valid/ready handshakes on both sides and compile-time optional debug ports. It generalises the team's conditionally-compiled port lists into a buffering stage. The datapath width, depth and almost-full threshold are parameters. `` `ifdef DIRECTIVE_FIFO_DBG `` adds saturating drop and high-water statistics ports. It sits between any producer/consumer pair that needs elastic buffering.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries, ≥2. Need not be a power of two.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when occupancy ≥ AF_THRESH. Legal range 1..DEPTH.
- `CW`, $clog2(DEPTH+1): width of the occupancy count. Derived; not to be overridden.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_valid` input 1: producer has a word.
- `wr_ready` output 1: FIFO accepts a word.
- `wr_data` input WIDTH: write word.
- `rd_valid` output 1: head word available.
- `rd_ready` input 1: consumer takes the head word.
- `rd_data` output WIDTH: head word (show-ahead).
- `count` output CW: current occupancy.
- `almost_full` output 1: count ≥ AF_THRESH.
- `drop_cnt` output 16: present only under `` `ifdef DIRECTIVE_FIFO_DBG ``. Saturating count of refused writes.
- `high_water` output CW: present only under `` `ifdef DIRECTIVE_FIFO_DBG ``. Maximum occupancy since reset.

## Operation
- **Push:** `wr_valid && wr_ready`.
- **Pop:** `rd_valid && rd_ready`.
- **Output definitions:**
  - `wr_ready = (count != DEPTH)`. It depends only on registered state and never on `rd_ready`. A full FIFO has no pass-through.
  - `rd_valid = (count != 0)`.
  - `rd_data` = memory[rd_ptr]. Its value when `rd_valid` is low is don't-care.
- **Pointer update:** `wr_ptr` and `rd_ptr` range over 0..DEPTH-1. Each increments on its event and wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- **Count update:**
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, and both pointers advance.
- **Empty edge cases:**
  - A pop when empty is impossible, because `rd_valid` is low.
  - A simultaneous push and pop at count=1 is legal: the old head leaves and the new word becomes the head.
- **Full edge case:** at count=DEPTH, `wr_ready` is low, so a concurrent pop frees a slot only for the following cycle.
- **Ordering:** strict FIFO, with no reordering and no duplication.
- **Debug statistics** (only under `DIRECTIVE_FIFO_DBG`):
  - `drop_cnt` increments on each cycle with `wr_valid && !wr_ready`. It saturates at 16'hFFFF.
  - `high_water` takes the next-state count whenever that exceeds its current value.
- **Reset:** `rst` clears pointers, `count`, `drop_cnt` and `high_water`. It overrides any same-cycle push or pop. Memory contents are not reset.
- No state machine beyond the pointer/count registers. The only mode is the compile-time debug option.

## Timing
- **Reset values:**
  - `wr_ready` = 1
  - `rd_valid` = 0
  - `count` = 0
  - `almost_full` = 0
  - `drop_cnt` = 0
  - `high_water` = 0
  - `rd_data` = X
- **Latency:**
  - A word pushed into an empty FIFO at edge N is visible on `rd_data` with `rd_valid` = 1 after edge N.
  - Write-to-read latency is therefore 1 cycle.
  - There is no combinational path from `wr_data` to `rd_data`.
- **Output timing:** `count`, `almost_full`, `wr_ready` and `rd_valid` are registered or decoded from registered state, and all update on the same edge as the event.
- **Debug counter timing:** `drop_cnt` increments on the edge that closes the refused-write cycle.
- **Reset mid-operation:** a reset asserted while the FIFO holds data makes all outputs take their reset values on the next edge. Data held before reset is never presented afterwards.

## Test plan
- **Fill and drain in order.** WIDTH=8, DEPTH=16. Push 0x00..0x0F back-to-back, then pop all.
  - `count` steps 0→16.
  - `almost_full` rises when count reaches 14.
  - `wr_ready` drops at 16.
  - Pop order is 0x00..0x0F.
  - `rd_valid` falls after the 16th pop.
- **Overflow refusal.** Hold `wr_valid` high for 3 cycles while full.
  - No memory change and `count` stays 16.
  - `drop_cnt` = 3 under DBG.
  - `high_water` = 16.
- **Simultaneous push and pop.**
  - At count=1, push 0xA5 while popping head 0x11: `count` stays 1, and `rd_data` = 0xA5 next cycle.
  - At count=16 with pop and `wr_valid`: the pop succeeds, the write is refused (`drop_cnt` +1), and `count` = 15.
- **Wrap-around with non-power-of-two depth.** DEPTH=5. Run 23 pushes and pops interleaved with random stalls against a scoreboard.
  - No mismatches.
  - Pointers never exceed 4.
- **Mid-stream reset.** With count=7, assert `rst` for 1 cycle together with push and pop.
  - Next cycle: `count` = 0, `rd_valid` = 0, `wr_ready` = 1.
  - The first word pushed afterwards is the first word popped.
- **Debug counter saturation.** Under DBG, force 65 540 refused-write cycles.
  - `drop_cnt` holds at 0xFFFF.
  - Without `DIRECTIVE_FIFO_DBG`, the module elaborates with neither port present.
